// File: rtl/shift_unit_seq_pkg.sv
// Shared definitions for the iterative shift/rotate unit: mode codes,
// FSM state encoding and a width helper for counters.
package shift_pkg;

  localparam logic [2:0] MODE_LSL = 3'd0;
  localparam logic [2:0] MODE_LSR = 3'd1;
  localparam logic [2:0] MODE_ASR = 3'd2;
  localparam logic [2:0] MODE_ROL = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Ceiling log2, never below 1 so it can size a vector directly.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational shift/rotate of a value by n (0..STEP) single positions.
// carry_out is the bit that left the operand on the last single step.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int STEP  = 1,
  parameter int N_W   = 1
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic [2:0]       i_mode,
  input  logic [N_W-1:0]   i_n,
  output logic [WIDTH-1:0] o_value,
  output logic             o_carry
);

  logic [WIDTH-1:0] w_v;
  logic             w_c;

  // Unrolled chain of single-position steps, each gated by k < n.
  always_comb begin
    w_v = i_value;
    w_c = 1'b0;
    for (int k = 0; k < STEP; k++) begin
      if (k < int'(i_n)) begin
        case (i_mode)
          MODE_LSR: begin
            w_c = w_v[0];
            w_v = {1'b0, w_v[WIDTH-1:1]};
          end
          MODE_ASR: begin
            w_c = w_v[0];
            w_v = {w_v[WIDTH-1], w_v[WIDTH-1:1]};
          end
          MODE_ROL: begin
            w_c = w_v[WIDTH-1];
            w_v = {w_v[WIDTH-2:0], w_v[WIDTH-1]};
          end
          MODE_ROR: begin
            w_c = w_v[0];
            w_v = {w_v[0], w_v[WIDTH-1:1]};
          end
          default: begin
            // LSL, and the unused codes 5-7 which alias to it
            w_c = w_v[WIDTH-1];
            w_v = {w_v[WIDTH-2:0], 1'b0};
          end
        endcase
      end
    end
  end

  assign o_value = w_v;
  assign o_carry = w_c;

endmodule

// File: rtl/shift_unit_seq.sv
// Iterative shift/rotate unit. Accepts one request in IDLE, shifts up to
// STEP positions per cycle in SHIFT, and holds the result in DONE until
// the consumer takes it.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, stays high with stable data until that
// edge. in_ready is high only in IDLE, out_valid only in DONE.
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 4,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] Rd1,
  input  logic [AMT_W-1:0] Rd2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output state_t           o_dbg_state
);

  localparam int CNT_W = clog2(WIDTH + 1);
  localparam int N_W   = clog2(STEP + 1);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  logic [WIDTH-1:0] r_val;
  logic [2:0]       r_mode;
  logic [CNT_W-1:0] r_rem;

  int               w_amt;
  int               w_eff_int;
  logic [CNT_W-1:0] w_eff;
  logic [N_W-1:0]   w_n;
  logic [CNT_W-1:0] w_rem_next;
  logic [WIDTH-1:0] w_step_val;
  logic             w_step_carry;

  // Effective count: rotates wrap modulo WIDTH, shifts saturate at WIDTH.
  always_comb begin
    w_amt     = int'(Rd2);
    w_eff_int = 0;
    if (mode == MODE_ROL || mode == MODE_ROR) begin
      w_eff_int = w_amt % WIDTH;
    end else begin
      w_eff_int = (w_amt >= WIDTH) ? WIDTH : w_amt;
    end
    w_eff = CNT_W'(w_eff_int);
  end

  // Positions to shift this cycle: min(STEP, remaining).
  always_comb begin
    w_n = (int'(r_rem) >= STEP) ? N_W'(STEP) : N_W'(r_rem);
    w_rem_next = r_rem - CNT_W'(w_n);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .N_W   (N_W)
  ) u_step (
    .i_value (r_val),
    .i_mode  (r_mode),
    .i_n     (w_n),
    .o_value (w_step_val),
    .o_carry (w_step_carry)
  );

  // FSM with working registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_val       <= '0;
      r_mode      <= MODE_LSL;
      r_rem       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_val      <= Rd1;
            r_mode     <= mode;
            r_rem      <= w_eff;
            if (!en || w_eff == '0) begin
              // Nothing to shift: disabled requests return 0
              r_result    <= en ? Rd1 : '0;
              r_carry     <= 1'b0;
              r_zero      <= en ? (Rd1 == '0) : 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          r_val <= w_step_val;
          r_rem <= w_rem_next;
          if (w_rem_next == '0) begin
            r_result    <= w_step_val;
            r_carry     <= w_step_carry;
            r_zero      <= (w_step_val == '0);
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign carry       = r_carry;
  assign zero        = r_zero;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq: a STEP=1 and a STEP=2 instance share inputs;
// each request pushes its expected {latency, carry, zero, result} to a
// queue that is popped when the selected instance raises out_valid.
module tb_shift_unit_seq;
  import shift_pkg::*;

  localparam int W  = 4;
  localparam int QW = 14;

  logic       clk;
  logic       rst_n;
  logic       in_valid1;
  logic       in_valid2;
  logic       en;
  logic [2:0] mode;
  logic [3:0] Rd1;
  logic [3:0] Rd2;
  logic       out_ready;
  logic       sel;

  logic       in_ready1, in_ready2, out_valid1, out_valid2;
  logic [3:0] result1, result2;
  logic       carry1, carry2, zero1, zero2;
  state_t     dbg1, dbg2;

  logic          w_in_ready, w_out_valid, w_carry, w_zero;
  logic [3:0]    w_result;
  logic [QW-1:0] exp_q[$];

  int n_checks;
  int n_errors;

  shift_unit_seq #(.WIDTH(W), .AMT_W(4), .STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .en(en), .mode(mode), .Rd1(Rd1), .Rd2(Rd2), .out_valid(out_valid1),
    .out_ready(out_ready), .result(result1), .carry(carry1), .zero(zero1),
    .o_dbg_state(dbg1)
  );

  shift_unit_seq #(.WIDTH(W), .AMT_W(4), .STEP(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .en(en), .mode(mode), .Rd1(Rd1), .Rd2(Rd2), .out_valid(out_valid2),
    .out_ready(out_ready), .result(result2), .carry(carry2), .zero(zero2),
    .o_dbg_state(dbg2)
  );

  assign w_in_ready  = sel ? in_ready2  : in_ready1;
  assign w_out_valid = sel ? out_valid2 : out_valid1;
  assign w_result    = sel ? result2    : result1;
  assign w_carry     = sel ? carry2     : carry1;
  assign w_zero      = sel ? zero2      : zero1;

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: closed-form shift by the effective count.
  function automatic logic [QW-1:0] model(input int step, input logic e,
                                          input logic [2:0] m, input logic [3:0] a,
                                          input logic [3:0] b);
    int eff;
    int lat;
    logic [3:0] r;
    logic c;
    if (m == 3'd3 || m == 3'd4) eff = int'(b) % 4;
    else eff = (int'(b) > 4) ? 4 : int'(b);
    r = 4'd0;
    c = 1'b0;
    if (!e) begin
      eff = 0;
    end else if (eff == 0) begin
      r = a;
    end else begin
      case (m)
        3'd1: begin r = a >> eff; c = a[eff-1]; end
        3'd2: begin r = 4'($signed(a) >>> eff); c = a[eff-1]; end
        3'd3: begin r = (a << eff) | (a >> (4 - eff)); c = r[0]; end
        3'd4: begin r = (a >> eff) | (a << (4 - eff)); c = r[3]; end
        default: begin r = a << eff; c = a[4-eff]; end
      endcase
    end
    lat = (eff == 0) ? 1 : 1 + (eff + step - 1) / step;
    return {8'(lat), c, (r == 4'd0), r};
  endfunction

  // Driver + scoreboard for one request, with optional output backpressure.
  task automatic do_req(input logic s, input logic e, input logic [2:0] m,
                        input logic [3:0] a, input logic [3:0] b, input int hold);
    int lat;
    logic [QW-1:0] ex;
    logic [3:0] held_r;
    logic held_c, held_z;
    @(posedge clk); #1;
    sel = s;
    #1;
    chk("in_ready_idle", 32'(w_in_ready), 32'd1);
    en = e; mode = m; Rd1 = a; Rd2 = b;
    if (s) in_valid2 = 1'b1; else in_valid1 = 1'b1;
    exp_q.push_back(model(s ? 2 : 1, e, m, a, b));
    @(posedge clk); #1;
    in_valid1 = 1'b0; in_valid2 = 1'b0;
    Rd1 = 4'($urandom_range(0, 15));
    Rd2 = 4'($urandom_range(0, 15));
    mode = 3'($urandom_range(0, 7));
    en = 1'($urandom_range(0, 1));
    lat = 1;
    while (!w_out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    ex = exp_q.pop_front();
    chk("latency", 32'(lat), 32'(ex[13:6]));
    chk("result", 32'(w_result), 32'(ex[3:0]));
    chk("carry", 32'(w_carry), 32'(ex[5]));
    chk("zero", 32'(w_zero), 32'(ex[4]));
    held_r = w_result; held_c = w_carry; held_z = w_zero;
    for (int i = 0; i < hold; i++) begin
      Rd1 = 4'($urandom_range(0, 15));
      if (s) in_valid2 = 1'b1; else in_valid1 = 1'b1;
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(w_out_valid), 32'd1);
      chk("bp_in_ready", 32'(w_in_ready), 32'd0);
      chk("bp_result", 32'(w_result), 32'(held_r));
      chk("bp_carry", 32'(w_carry), 32'(held_c));
      chk("bp_zero", 32'(w_zero), 32'(held_z));
    end
    in_valid1 = 1'b0; in_valid2 = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_out_valid", 32'(w_out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(w_in_ready), 32'd1);
  endtask

  // Directed sequence followed by a short random sweep.
  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0; en = 1'b0;
    mode = 3'd0; Rd1 = 4'd0; Rd2 = 4'd0; out_ready = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready1), 32'd1);
    chk("rst_out_valid", 32'(out_valid1), 32'd0);
    chk("rst_result", 32'(result1), 32'd0);
    chk("rst_carry", 32'(carry1), 32'd0);
    chk("rst_zero", 32'(zero1), 32'd0);
    chk("rst_state", 32'(dbg1), 32'(ST_IDLE));
    chk("rst_in_ready2", 32'(in_ready2), 32'd1);
    rst_n = 1'b1;

    do_req(1'b0, 1'b1, 3'd0, 4'b0011, 4'd2, 0);   // LSL -> 1100
    do_req(1'b0, 1'b1, 3'd2, 4'b1000, 4'd5, 0);   // ASR saturated -> 1111 c=1
    do_req(1'b0, 1'b1, 3'd4, 4'b0001, 4'd5, 0);   // ROR eff=1 -> 1000 c=1
    do_req(1'b1, 1'b1, 3'd1, 4'b1011, 4'd3, 0);   // STEP=2 LSR -> 0001 c=0
    do_req(1'b0, 1'b0, 3'd0, 4'b1111, 4'd1, 0);   // disabled -> 0000 z=1
    do_req(1'b0, 1'b1, 3'd7, 4'b0101, 4'd1, 0);   // code 7 acts as LSL
    do_req(1'b0, 1'b1, 3'd3, 4'b1001, 4'd1, 5);   // ROL with backpressure

    // Reset during SHIFT aborts the operation
    @(posedge clk); #1;
    sel = 1'b0;
    en = 1'b1; mode = 3'd0; Rd1 = 4'b0110; Rd2 = 4'd4; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(posedge clk); #1;
    chk("mid_state_shift", 32'(dbg1), 32'(ST_SHIFT));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_in_ready", 32'(in_ready1), 32'd1);
    chk("abort_out_valid", 32'(out_valid1), 32'd0);
    chk("abort_result", 32'(result1), 32'd0);
    chk("abort_carry", 32'(carry1), 32'd0);
    chk("abort_zero", 32'(zero1), 32'd0);
    chk("abort_state", 32'(dbg1), 32'(ST_IDLE));
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_result", 32'(out_valid1), 32'd0);
    do_req(1'b0, 1'b1, 3'd1, 4'b1100, 4'd2, 0);   // fresh request after reset

    for (int i = 0; i < 16; i++) begin
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
